// File: rtl/nes_loader.sv
// nes_loader: host-side sequencer that loads a program image into the NES over its command port.
//   clk, reset          : clock, synchronous active-high reset
//   start, abort        : begin a load (ignored while busy) / return to IDLE from any state
//   base_addr, length,
//   entry_addr          : load parameters, latched on an accepted start
//   in_valid, in_data,
//   in_ready            : byte-stream image source handshake
//   chipselect, write,
//   address, writedata  : command port toward the NES ({op, data} in writedata)
//   busy, done          : sequence in progress / CPU released and running
module nes_loader #(
    parameter int          RESET_CYCLES = 4,
    parameter logic [7:0]  RUN_OP       = 8'hFF
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic        abort,
    input  logic [15:0] base_addr,
    input  logic [15:0] length,
    input  logic [15:0] entry_addr,
    input  logic        in_valid,
    input  logic [7:0]  in_data,
    output logic        in_ready,
    output logic        chipselect,
    output logic        write,
    output logic [15:0] address,
    output logic [15:0] writedata,
    output logic        busy,
    output logic        done
);
    localparam logic [15:0] RST_LAST = 16'(RESET_CYCLES - 1);

    typedef enum logic [2:0] {IDLE, RST, LOAD, START, RUN} state_t;

    state_t      state;
    logic [15:0] base, len, entry, cnt, rcnt;
    logic        rdy;
    logic        hs;

    // abort must refuse a byte in the very cycle it is raised, so the
    // registered ready is gated combinationally here.
    assign in_ready = rdy & ~abort;
    assign hs       = in_valid & in_ready;

    // state names the phase whose command is emitted at the next edge;
    // every output is the registered result of that decision.
    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= IDLE;
            base       <= '0;
            len        <= '0;
            entry      <= '0;
            cnt        <= '0;
            rcnt       <= '0;
            rdy        <= 1'b0;
            chipselect <= 1'b0;
            write      <= 1'b0;
            address    <= '0;
            writedata  <= 16'h0200;
            busy       <= 1'b0;
            done       <= 1'b0;
        end else begin
            chipselect <= 1'b1;
            write      <= 1'b0;
            address    <= '0;
            rdy        <= 1'b0;
            done       <= 1'b0;
            busy       <= 1'b1;
            if (abort) begin
                state     <= IDLE;
                base      <= '0;
                len       <= '0;
                entry     <= '0;
                cnt       <= '0;
                rcnt      <= '0;
                writedata <= 16'h0200;
                busy      <= 1'b0;
            end else begin
                case (state)
                    IDLE, RUN: begin
                        if (start) begin
                            base      <= base_addr;
                            len       <= length;
                            entry     <= entry_addr;
                            cnt       <= '0;
                            rcnt      <= '0;
                            state     <= RST;
                            writedata <= 16'h0000;
                        end else begin
                            writedata <= (state == RUN) ? {RUN_OP, 8'h00} : 16'h0200;
                            done      <= (state == RUN);
                            busy      <= 1'b0;
                        end
                    end
                    RST: begin
                        if (rcnt == RST_LAST) begin
                            if (len != 16'd0) begin
                                state     <= LOAD;
                                rdy       <= 1'b1;
                                writedata <= 16'h0200;
                            end else begin
                                // empty image: START_CPU is emitted straight from reset
                                state     <= RUN;
                                writedata <= 16'h0100;
                                address   <= entry;
                            end
                        end else begin
                            rcnt      <= rcnt + 16'd1;
                            writedata <= 16'h0000;
                        end
                    end
                    LOAD: begin
                        if (hs) begin
                            writedata <= {8'h03, in_data};
                            address   <= base + cnt;
                            write     <= 1'b1;
                            cnt       <= cnt + 16'd1;
                            // equality before increment keeps length 16'hFFFF safe
                            rdy       <= (cnt != len - 16'd1);
                            if (cnt == len - 16'd1)
                                state <= START;
                        end else begin
                            writedata <= 16'h0200;
                            rdy       <= 1'b1;
                        end
                    end
                    START: begin
                        writedata <= 16'h0100;
                        address   <= entry;
                        state     <= RUN;
                    end
                    default: state <= IDLE;
                endcase
            end
        end
    end
endmodule

// File: tb/tb_nes_loader.sv
// tb_nes_loader: directed self-checking bench for nes_loader with an expected-output scoreboard.
module tb_nes_loader;
    logic        clk = 1'b0;
    logic        reset, start, abort, in_valid;
    logic [15:0] base_addr, length, entry_addr;
    logic [7:0]  in_data;
    logic        in_ready, chipselect, write, busy, done;
    logic [15:0] address, writedata;

    int compared = 0;
    int mismatched = 0;
    string phase = "init";

    typedef struct {
        logic [15:0] wd;
        logic [15:0] addr;
        logic        wr;
        logic        rdy;
        logic        bz;
        logic        dn;
        logic        cs;
    } exp_t;
    exp_t sb[$];

    nes_loader #(.RESET_CYCLES(4), .RUN_OP(8'hFF)) dut (
        .clk(clk), .reset(reset), .start(start), .abort(abort),
        .base_addr(base_addr), .length(length), .entry_addr(entry_addr),
        .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready),
        .chipselect(chipselect), .write(write), .address(address),
        .writedata(writedata), .busy(busy), .done(done)
    );

    always #5 clk = ~clk;

    task automatic check_front(input int n);
        exp_t e;
        e = sb.pop_front();
        compared++;
        assert ({writedata, address, write, in_ready, busy, done, chipselect} ===
                {e.wd, e.addr, e.wr, e.rdy, e.bz, e.dn, e.cs})
        else begin
            mismatched++;
            $error("FAIL %s[%0d] obs wd=%h addr=%h wr=%b rdy=%b busy=%b done=%b cs=%b exp wd=%h addr=%h wr=%b rdy=%b busy=%b done=%b cs=%b",
                   phase, n, writedata, address, write, in_ready, busy, done, chipselect,
                   e.wd, e.addr, e.wr, e.rdy, e.bz, e.dn, e.cs);
        end
    endtask

    // Drive one cycle of inputs, push the outputs expected after the edge, then compare.
    task automatic cyc(input logic st, input logic ab, input logic v, input logic [7:0] d,
                       input logic [15:0] wd, input logic [15:0] a, input logic wr,
                       input logic rdy, input logic bz, input logic dn, input int n);
        start = st; abort = ab; in_valid = v; in_data = d;
        sb.push_back('{wd, a, wr, rdy, bz, dn, 1'b1});
        @(posedge clk); #1;
        check_front(n);
    endtask

    // Start a load and walk through the RESET_CPU phase, ending on LOAD or START_CPU.
    task automatic begin_load(input logic [15:0] b, input logic [15:0] l, input logic [15:0] e);
        base_addr = b; length = l; entry_addr = e;
        cyc(1, 0, 0, 8'h00, 16'h0000, 16'h0000, 0, 0, 1, 0, 0);
        for (int i = 1; i < 4; i++) cyc(0, 0, 0, 8'h00, 16'h0000, 16'h0000, 0, 0, 1, 0, i);
        if (l != 16'd0) cyc(0, 0, 0, 8'h00, 16'h0200, 16'h0000, 0, 1, 1, 0, 4);
        else            cyc(0, 0, 0, 8'h00, 16'h0100, e,        0, 0, 1, 0, 4);
    endtask

    task automatic finish_run(input logic [15:0] e);
        cyc(0, 0, 0, 8'h00, 16'h0100, e,        0, 0, 1, 0, 90);
        cyc(0, 0, 0, 8'h00, 16'hFF00, 16'h0000, 0, 0, 0, 1, 91);
        cyc(0, 0, 0, 8'h00, 16'hFF00, 16'h0000, 0, 0, 0, 1, 92);
    endtask

    initial begin
        reset = 1; start = 0; abort = 0; in_valid = 0; in_data = 0;
        base_addr = 0; length = 0; entry_addr = 0;
        repeat (2) @(posedge clk);
        #1;
        phase = "reset_vals";
        sb.push_back('{16'h0200, 16'h0000, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0});
        check_front(0);
        reset = 0;

        phase = "idle";
        for (int i = 0; i < 10; i++) cyc(0, 0, 0, 8'h00, 16'h0200, 16'h0000, 0, 0, 0, 0, i);

        phase = "b2b";
        begin_load(16'h8000, 16'd3, 16'h8000);
        cyc(0, 0, 1, 8'hA9, 16'h03A9, 16'h8000, 1, 1, 1, 0, 0);
        cyc(0, 0, 1, 8'h01, 16'h0301, 16'h8001, 1, 1, 1, 0, 1);
        cyc(0, 0, 1, 8'h00, 16'h0300, 16'h8002, 1, 0, 1, 0, 2);
        finish_run(16'h8000);

        phase = "toggle";
        begin_load(16'h8000, 16'd3, 16'h8000);
        cyc(0, 0, 1, 8'hA9, 16'h03A9, 16'h8000, 1, 1, 1, 0, 0);
        cyc(0, 0, 0, 8'h00, 16'h0200, 16'h0000, 0, 1, 1, 0, 1);
        cyc(0, 0, 1, 8'h01, 16'h0301, 16'h8001, 1, 1, 1, 0, 2);
        cyc(0, 0, 0, 8'h00, 16'h0200, 16'h0000, 0, 1, 1, 0, 3);
        cyc(0, 0, 1, 8'h00, 16'h0300, 16'h8002, 1, 0, 1, 0, 4);
        finish_run(16'h8000);

        phase = "wrap";
        begin_load(16'hFFFE, 16'd4, 16'h0000);
        cyc(0, 0, 1, 8'h11, 16'h0311, 16'hFFFE, 1, 1, 1, 0, 0);
        cyc(1, 0, 1, 8'h22, 16'h0322, 16'hFFFF, 1, 1, 1, 0, 1);
        cyc(0, 0, 1, 8'h33, 16'h0333, 16'h0000, 1, 1, 1, 0, 2);
        cyc(0, 0, 1, 8'h44, 16'h0344, 16'h0001, 1, 0, 1, 0, 3);
        finish_run(16'h0000);

        phase = "len0";
        begin_load(16'h4000, 16'd0, 16'h1234);
        cyc(0, 0, 1, 8'h55, 16'hFF00, 16'h0000, 0, 0, 0, 1, 0);

        phase = "abort";
        begin_load(16'h8000, 16'd3, 16'h8000);
        cyc(0, 0, 1, 8'hA9, 16'h03A9, 16'h8000, 1, 1, 1, 0, 0);
        start = 1; abort = 1; in_valid = 1; in_data = 8'h01;
        #1;
        compared++;
        assert (in_ready === 1'b0)
        else begin
            mismatched++;
            $error("FAIL abort_ready obs=%b exp=0", in_ready);
        end
        cyc(1, 1, 1, 8'h01, 16'h0200, 16'h0000, 0, 0, 0, 0, 1);
        cyc(0, 0, 1, 8'h01, 16'h0200, 16'h0000, 0, 0, 0, 0, 2);

        phase = "restart";
        begin_load(16'h8000, 16'd3, 16'h8000);
        cyc(0, 0, 1, 8'h01, 16'h0301, 16'h8000, 1, 1, 1, 0, 0);
        cyc(0, 0, 1, 8'h02, 16'h0302, 16'h8001, 1, 1, 1, 0, 1);
        cyc(0, 0, 1, 8'h03, 16'h0303, 16'h8002, 1, 0, 1, 0, 2);
        finish_run(16'h8000);

        phase = "midreset";
        begin_load(16'h8000, 16'd3, 16'h8000);
        reset = 1; in_valid = 0;
        @(posedge clk); #1;
        sb.push_back('{16'h0200, 16'h0000, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0});
        check_front(0);
        reset = 0;

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end
endmodule
